receiver_core: RTL
==================

# receiver_core

Serial receive engine for the transceiver, the far end of the transmitter's start/data/stop link. It samples `sda` on rising edges of the incoming serial clock and assembles right-justified words of a programmed bit length. It drives an ACK/NACK bit after every word and checks the stop bit. Completed words go to a two-slot ping-pong buffer that the host drains with a valid/ready handshake.

## Interface
- No parameters; word width is fixed at 32.
- `clk` in 1: system clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `scl` in 1: serial bit clock from the transmitter (`clock` output), asynchronous to nothing, toggles at most every `clk`.
- `sda_in` in 1: sampled line value from the gateway.
- `sda_out` out 1: value driven during ACK slot.
- `sda_oe` out 1: gateway output enable (1 = drive `sda`).
- `data` in 8, `write` in 1, `addin` in 4: config write port. Addr 0 = size (bits/word), addr 1 = burst (words/frame), addr 2 = clear sticky flags; other addresses are ignored.
- `rxdata` out 32, `rxvalid` out 1, `rxready` in 1: receive handshake.
- `busy` out 1: frame in progress (state ≠ IDLE).
- `overrun` out 1, `frame_err` out 1: sticky error flags.

## Operation
- Strobe: `scl_q` is the registered `scl`; strobe = `scl & ~scl_q`. All FSM steps occur only on strobe cycles.
- Config: on `write`, addr 0 loads size, addr 1 loads burst, addr 2 clears `overrun` and `frame_err`. Size 0 or >32 is used as 32; burst 0 is used as 1. Values are latched into counters at frame start; writes during a frame affect only the next frame.
- FSM states: IDLE, DATA, ACK, STOP.
  - IDLE: on a strobe with `sda_in`=0, this is the start bit. Load bitcnt=size and wordcnt=burst, then go to DATA. A strobe with `sda_in`=1 leaves the FSM in IDLE.
  - DATA: on each strobe, shift = {shift[30:0], `sda_in`} (MSB first) and decrement bitcnt. On the strobe where bitcnt==1, the word is complete: the push is attempted and the FSM goes to ACK.
  - ACK: `sda_oe`=1. `sda_out`=0 if the push was accepted. `sda_out`=1 (NACK) if it was rejected; in that case `overrun` is set and the word is dropped. On the next strobe, release the line and decrement wordcnt. If wordcnt was 1, go to STOP; otherwise reload bitcnt and go to DATA.
  - STOP: on a strobe, `sda_in`=1 goes to IDLE. `sda_in`=0 sets `frame_err`, then goes to IDLE; no resync is attempted.
- Shift register is cleared at frame start, so words with size<32 appear zero-extended in `rxdata[31:size]`.
- Ping-pong buffer: 2 slots, wr/rd pointers, count 0..2.
  - `rxvalid` = count≠0; `rxdata` = slot[rd].
  - Pop occurs when `rxvalid & rxready`.
  - A push is accepted if count<2, or if a pop occurs in the same cycle (count=2 with simultaneous pop gives accept, count stays 2).
  - Push and pop in the same cycle at count 1 leaves count at 1.
- Reset mid-frame aborts immediately. No partial word is delivered and the line is released the same cycle reset is sampled.

## Timing
- Reset values: `sda_oe`=0, `sda_out`=1, `rxvalid`=0, `rxdata`=0, `busy`=0, `overrun`=0, `frame_err`=0. Size reg = 32, burst reg = 1, FSM = IDLE, buffer empty, `scl_q`=0.
- `rxvalid` rises the `clk` after the last-bit strobe (1-cycle latency).
- `sda_oe` rises the `clk` after the last-bit strobe and falls the `clk` after the following strobe.
- `busy` rises the `clk` after the start-bit strobe and falls the `clk` after the stop-bit strobe.
- `rxdata` is stable while `rxvalid` and not `rxready`.
- Flag set and clear in the same cycle: set wins.

## Structure
- Package `receiver_pkg` holds:
  - state enum (IDLE/DATA/ACK/STOP);
  - config address constants (SIZE_ADDR=0, BURST_ADDR=1, CLR_ADDR=2);
  - defaults (DEF_SIZE=32, DEF_BURST=1);
  - word width constant 32.
- One sub-module, `rx_pingpong`: the 2-slot buffer with push/accept/pop/count logic. FSM, counters, config and strobe logic stay in `receiver_core`.

## Test plan
- Size=8, burst=1, send start, 0xA5 MSB-first, then stop=1 → `rxdata`=0x000000A5, `rxvalid` 1 cycle after the 8th strobe, ACK slot `sda_out`=0, no flags set.
- Size=32, burst=3, words 0xDEADBEEF, 0x12345678, 0xCAFEF00D, `rxready` held 0 → first two words are ACKed, third is NACKed, `overrun`=1, and draining returns only the first two words in order.
- Buffer full with `rxready`=1 exactly on the cycle the third word completes → word is accepted (ACK), count stays 2, and all three words are read out.
- Stop bit sent as 0 → `frame_err`=1, FSM returns to IDLE, and the next frame is received correctly. A write to addr 2 clears the flag.
- Size written as 0 → 32-bit words are received. A size write of 4 issued mid-frame leaves the current frame at 32 bits; the next frame uses 4 bits (0x0000000B for bits 1011).
- Reset asserted mid-word in DATA → next cycle `busy`=0, `sda_oe`=0, `rxvalid`=0, and the size/burst registers return to 32/1.

Source files
------------

// File: rtl/receiver_pkg.sv
// ==========================================================================
// receiver_pkg: shared types and constants for the serial receive engine
// Rev 1.0
// ==========================================================================
`default_nettype none

package receiver_pkg;

   localparam int WORD_W = 32;

   localparam logic [3:0] SIZE_ADDR  = 4'd0;
   localparam logic [3:0] BURST_ADDR = 4'd1;
   localparam logic [3:0] CLR_ADDR   = 4'd2;

   localparam logic [7:0] DEF_SIZE  = 8'd32;
   localparam logic [7:0] DEF_BURST = 8'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      ACK  = 2'd2,
      STOP = 2'd3
   } state_t;

   // Out-of-range sizes fall back to a full word.
   function automatic logic [5:0] eff_size(input logic [7:0] s);
      if (s == 8'd0 || s > 8'd32) return 6'd32;
      return s[5:0];
   endfunction

   function automatic logic [7:0] eff_burst(input logic [7:0] b);
      if (b == 8'd0) return 8'd1;
      return b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rx_pingpong.sv
// ==========================================================================
// rx_pingpong: two-slot receive buffer with valid/ready drain side
// Rev 1.0
// ==========================================================================
`default_nettype none

module rx_pingpong
   import receiver_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   output logic              accept,
   input  logic              ready,
   output logic              valid,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] slot [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              pop;
   logic              push_ok;

   assign valid   = (count != 2'd0);
   assign rdata   = slot[rd_ptr];
   assign pop     = valid & ready;
   // A full buffer still takes a word when the host frees a slot this cycle.
   assign accept  = (count != 2'd2) | pop;
   assign push_ok = push & accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) slot[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/receiver_core.sv
// ==========================================================================
// receiver_core: start/data/ACK/stop serial receiver feeding a ping-pong buffer
// Rev 1.0
// ==========================================================================
`default_nettype none

module receiver_core
   import receiver_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              scl,
   input  logic              sda_in,
   output logic              sda_out,
   output logic              sda_oe,
   input  logic [7:0]        data,
   input  logic              write,
   input  logic [3:0]        addin,
   output logic [WORD_W-1:0] rxdata,
   output logic              rxvalid,
   input  logic              rxready,
   output logic              busy,
   output logic              overrun,
   output logic              frame_err
);

   state_t            state;
   logic              scl_q;
   logic              strobe;
   logic [7:0]        size_reg;
   logic [7:0]        burst_reg;
   logic [5:0]        frame_size;
   logic [5:0]        bitcnt;
   logic [7:0]        wordcnt;
   logic [WORD_W-1:0] shift;
   logic [WORD_W-1:0] shift_next;
   logic              nack;
   logic              push;
   logic              accept;
   logic              set_ovr;
   logic              set_ferr;
   logic              clr_flags;

   assign strobe     = scl & ~scl_q;
   assign shift_next = {shift[WORD_W-2:0], sda_in};
   assign push       = strobe && (state == DATA) && (bitcnt == 6'd1);
   assign set_ovr    = push & ~accept;
   assign set_ferr   = strobe && (state == STOP) && !sda_in;
   assign clr_flags  = write && (addin == CLR_ADDR);

   assign busy    = (state != IDLE);
   assign sda_oe  = (state == ACK);
   assign sda_out = (state == ACK) ? nack : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_q     <= 1'b0;
         size_reg  <= DEF_SIZE;
         burst_reg <= DEF_BURST;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         scl_q <= scl;
         if (write && addin == SIZE_ADDR)  size_reg  <= data;
         if (write && addin == BURST_ADDR) burst_reg <= data;
         overrun   <= (overrun & ~clr_flags) | set_ovr;
         frame_err <= (frame_err & ~clr_flags) | set_ferr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         frame_size <= 6'd32;
         bitcnt     <= 6'd0;
         wordcnt    <= 8'd0;
         shift      <= '0;
         nack       <= 1'b0;
      end else if (strobe) begin
         case (state)
            IDLE: begin
               if (!sda_in) begin
                  frame_size <= eff_size(size_reg);
                  bitcnt     <= eff_size(size_reg);
                  wordcnt    <= eff_burst(burst_reg);
                  shift      <= '0;
                  state      <= DATA;
               end
            end
            DATA: begin
               shift  <= shift_next;
               bitcnt <= bitcnt - 6'd1;
               if (bitcnt == 6'd1) begin
                  nack  <= ~accept;
                  state <= ACK;
               end
            end
            ACK: begin
               wordcnt <= wordcnt - 8'd1;
               if (wordcnt == 8'd1) begin
                  state <= STOP;
               end else begin
                  // Clearing per word keeps short words zero-extended.
                  bitcnt <= frame_size;
                  shift  <= '0;
                  state  <= DATA;
               end
            end
            STOP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   rx_pingpong u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shift_next),
      .accept    (accept),
      .ready     (rxready),
      .valid     (rxvalid),
      .rdata     (rxdata)
   );

endmodule

`default_nettype wire
